id_stage_pipelined: RTL and testbench

//  Parametrised RV32I decode stage with integrated register file and registered ID/EX output.

---
 rtl/id_stage_pipelined.sv | 213 +++++++++++++++++++++
 tb/tb_id_stage_pipelined.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipelined.sv
// rtl/id_stage_pipelined.sv - RV32I/E decode stage with register file, hazard stall and ID/EX register
// Optional same-cycle WB-to-read bypass when WB_BYPASS_EN is defined.
module id_stage_pipelined #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       insn,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rd,
    output logic              out_reg_we,
    output logic              out_mem_we,
    output logic              out_reg_sel,
    output logic [2:0]        out_branch,
    output logic [3:0]        out_alu,
    output logic              out_illegal
);
    localparam int IDX_W = $clog2(NREGS);
    localparam logic [5:0] NREGS6 = 6'(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign f3     = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign f7     = insn[31:25];

    logic        legal, rs1_used, rs2_used, rd_used, is_load, is_store, idx_bad, illegal;
    logic [31:0] imm32;
    logic [2:0]  branch;
    logic [3:0]  alu;

    // Branch codes: funct3 except beq->010 (000 = none); 011 = jump, where alu 1110
    // marks a pc-relative target (jal) and alu 0000 an rs1-relative one (jalr).
    always_comb begin
        legal    = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_used  = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        imm32    = 32'd0;
        branch   = 3'b000;
        alu      = 4'b0000;
        case (opcode)
            OP_LUI: begin
                rd_used = 1'b1;
                imm32   = {insn[31:12], 12'b0};
                alu     = 4'b1111;
            end
            OP_AUIPC: begin
                rd_used = 1'b1;
                imm32   = {insn[31:12], 12'b0};
            end
            OP_JAL: begin
                rd_used = 1'b1;
                imm32   = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                branch  = 3'b011;
                alu     = 4'b1110;
            end
            OP_JALR: begin
                legal    = (f3 == 3'b000);
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                imm32    = {{20{insn[31]}}, insn[31:20]};
                branch   = 3'b011;
            end
            OP_BRANCH: begin
                legal    = (f3 != 3'b010) && (f3 != 3'b011);
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
                branch   = (f3 == 3'b000) ? 3'b010 : f3;
            end
            OP_LOAD: begin
                legal    = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                is_load  = 1'b1;
                imm32    = {{20{insn[31]}}, insn[31:20]};
            end
            OP_STORE: begin
                legal    = (f3 <= 3'b010);
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                is_store = 1'b1;
                imm32    = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            end
            OP_IMM: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                imm32    = {{20{insn[31]}}, insn[31:20]};
                alu      = {1'b0, f3};
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    alu   = {insn[30], f3};
                end
            end
            OP_REG: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                rd_used  = 1'b1;
                legal    = (f7 == 7'b0000000) ||
                           ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                alu      = {insn[30], f3};
            end
            default: legal = 1'b0;
        endcase
    end

    assign idx_bad = (rs1_used && ({1'b0, rs1} >= NREGS6)) ||
                     (rs2_used && ({1'b0, rs2} >= NREGS6)) ||
                     (rd_used  && ({1'b0, rd}  >= NREGS6));
    assign illegal = ~legal | idx_bad;

    logic hazard;
    assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                    ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));

    assign in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready);

    logic fire_in, fire_out, wb_en;
    assign fire_in  = in_valid & in_ready;
    assign fire_out = out_valid & out_ready;
    assign wb_en    = wb_we && (wb_rd != 5'd0) && ({1'b0, wb_rd} < NREGS6);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[IDX_W-1:0]];
        rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[IDX_W-1:0]];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_rd == rs1)) rs1_val = wb_data;
        if (wb_en && (wb_rd == rs2)) rs2_val = wb_data;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_rd[IDX_W-1:0]] <= wb_data;
        end
    end

    // ID/EX register: flush only kills valid; bubbles leave the fields as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_reg_we  <= 1'b0;
            out_mem_we  <= 1'b0;
            out_reg_sel <= 1'b0;
            out_branch  <= '0;
            out_alu     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire_in) begin
            out_valid   <= 1'b1;
            out_pc      <= pc;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_imm     <= XLEN'($signed(imm32));
            out_rd      <= rd;
            out_reg_we  <= ~illegal & rd_used & (rd != 5'd0);
            out_mem_we  <= ~illegal & is_store;
            out_reg_sel <= is_load;
            out_branch  <= illegal ? 3'b000 : branch;
            out_alu     <= alu;
            out_illegal <= illegal;
        end else if (fire_out) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb/tb_id_stage_pipelined.sv - directed table-driven bench for id_stage_pipelined
module tb_id_stage_pipelined;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, wb_we, ex_is_load, out_ready;
    logic [31:0] insn, pc, wb_data;
    logic [4:0]  wb_rd, ex_rd;

    logic        in_ready, out_valid, out_reg_we, out_mem_we, out_reg_sel, out_illegal;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic [2:0]  out_branch;
    logic [3:0]  out_alu;

    logic        r16_in_ready, r16_valid, r16_reg_we, r16_mem_we, r16_reg_sel, r16_illegal;
    logic [31:0] r16_pc, r16_rs1_val, r16_rs2_val, r16_imm;
    logic [4:0]  r16_rd;
    logic [2:0]  r16_branch;
    logic [3:0]  r16_alu;

    id_stage_pipelined dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .insn(insn), .pc(pc),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_reg_we(out_reg_we), .out_mem_we(out_mem_we),
        .out_reg_sel(out_reg_sel), .out_branch(out_branch), .out_alu(out_alu),
        .out_illegal(out_illegal)
    );

    id_stage_pipelined #(.NREGS(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r16_in_ready), .insn(insn), .pc(pc),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .out_valid(r16_valid), .out_ready(out_ready),
        .out_pc(r16_pc), .out_rs1_val(r16_rs1_val), .out_rs2_val(r16_rs2_val), .out_imm(r16_imm),
        .out_rd(r16_rd), .out_reg_we(r16_reg_we), .out_mem_we(r16_mem_we),
        .out_reg_sel(r16_reg_sel), .out_branch(r16_branch), .out_alu(r16_alu),
        .out_illegal(r16_illegal)
    );

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_we;
        logic        reg_sel;
        logic [2:0]  br;
        logic [3:0]  alu;
        logic        ill;
    } vec_t;

    vec_t vecs[13];
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] byp_exp;
`ifdef WB_BYPASS_EN
        byp_exp = 32'h0000_00AA;
`else
        byp_exp = 32'h0000_1234;
`endif
        //           insn          rs1v          rs2v          imm           rd  rwe mwe sel br      alu      ill
        vecs[0]  = '{32'hFFF28313, 32'h00001234, 32'h0,        32'hFFFFFFFF, 6,  1,  0,  0,  3'b000, 4'b0000, 0};
        vecs[1]  = '{32'h000283B3, 32'h00001234, 32'h0,        32'h0,        7,  1,  0,  0,  3'b000, 4'b0000, 0};
        vecs[2]  = '{32'h40530433, 32'h00000055, 32'h00001234, 32'h0,        8,  1,  0,  0,  3'b000, 4'b1000, 0};
        vecs[3]  = '{32'h00532423, 32'h00000055, 32'h00001234, 32'h00000008, 8,  0,  1,  0,  3'b000, 4'b0000, 0};
        vecs[4]  = '{32'hFFC2A483, 32'h00001234, 32'h0,        32'hFFFFFFFC, 9,  1,  0,  1,  3'b000, 4'b0000, 0};
        vecs[5]  = '{32'hFE628CE3, 32'h00001234, 32'h00000055, 32'hFFFFFFF8, 25, 0,  0,  0,  3'b010, 4'b0000, 0};
        vecs[6]  = '{32'h12345537, 32'h0,        32'h0,        32'h12345000, 10, 1,  0,  0,  3'b000, 4'b1111, 0};
        vecs[7]  = '{32'h001000EF, 32'h0,        32'h0,        32'h00000800, 1,  1,  0,  0,  3'b011, 4'b1110, 0};
        vecs[8]  = '{32'h4032D593, 32'h00001234, 32'h0,        32'h00000403, 11, 1,  0,  0,  3'b000, 4'b1101, 0};
        vecs[9]  = '{32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        31, 0,  0,  0,  3'b000, 4'b0000, 1};
        vecs[10] = '{32'h00000013, 32'h0,        32'h0,        32'h0,        0,  0,  0,  0,  3'b000, 4'b0000, 0};
        vecs[11] = '{32'h80000197, 32'h0,        32'h0,        32'h80000000, 3,  1,  0,  0,  3'b000, 4'b0000, 0};
        vecs[12] = '{32'h02000033, 32'h0,        32'h0,        32'h0,        0,  0,  0,  0,  3'b000, 4'b0000, 1};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; ex_is_load = 1'b0;
        out_ready = 1'b1; insn = 32'h0; pc = 32'h0; wb_data = 32'h0; wb_rd = 5'd0; ex_rd = 5'd0;
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_ctrl", {16'b0, out_rd, out_reg_we, out_mem_we, out_reg_sel, out_branch, out_alu, out_illegal},
              32'd0);

        // Every architectural register reads 0 after reset.
        in_valid = 1'b1;
        for (int i = 1; i < 32; i++) begin
            insn = (32'(i) << 15) | 32'h13;
            tick();
            check($sformatf("rst_x%0d", i), out_rs1_val, 32'd0);
        end
        in_valid = 1'b0;

        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234; tick();
        wb_rd = 5'd6; wb_data = 32'h55; tick();
        wb_rd = 5'd0; wb_data = 32'hFFFF; tick();
        wb_we = 1'b0;

        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            insn = vecs[i].insn;
            pc = 32'h100 + 32'(4 * i);
            tick();
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d_pc", i), out_pc, 32'h100 + 32'(4 * i));
            check($sformatf("v%0d_rs1", i), out_rs1_val, vecs[i].rs1v);
            check($sformatf("v%0d_rs2", i), out_rs2_val, vecs[i].rs2v);
            check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d_ctrl", i),
                  {20'b0, out_reg_we, out_mem_we, out_reg_sel, out_branch, out_alu, out_illegal},
                  {20'b0, vecs[i].reg_we, vecs[i].mem_we, vecs[i].reg_sel, vecs[i].br, vecs[i].alu, vecs[i].ill});
        end

        // Load-use hazard: bubble, then accept once the load leaves EX.
        ex_is_load = 1'b1; ex_rd = 5'd8; insn = 32'h12345537;
        #1;
        check("nohaz_unused_rs", {31'b0, in_ready}, 32'd1);
        ex_rd = 5'd5; insn = 32'h000283B3; pc = 32'h200;
        #1;
        check("haz_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("haz_bubble", {31'b0, out_valid}, 32'd0);
        ex_is_load = 1'b0;
        #1;
        check("haz_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("haz_accept_valid", {31'b0, out_valid}, 32'd1);
        check("haz_accept_rd", {27'b0, out_rd}, 32'd7);
        check("haz_accept_pc", out_pc, 32'h200);

        // Downstream stall for three cycles.
        out_ready = 1'b0; insn = 32'h00000613; pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
            tick();
            check($sformatf("stall%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("stall%0d_rd", i), {27'b0, out_rd}, 32'd7);
            check($sformatf("stall%0d_pc", i), out_pc, 32'h200);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("b2b0_rd", {27'b0, out_rd}, 32'd12);
        insn = 32'h00000693; pc = 32'h304;
        tick();
        check("b2b1_rd", {27'b0, out_rd}, 32'd13);
        check("b2b1_pc", out_pc, 32'h304);

        // Flush drops the presented instruction and kills the held one.
        insn = 32'h00000713; pc = 32'h308; flush = 1'b1;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_not_captured", {27'b0, out_rd}, 32'd13);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("post_flush_valid", {31'b0, out_valid}, 32'd0);

        // Same-cycle WB write and read of x5.
        in_valid = 1'b1; insn = 32'hFFF28313;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
        tick();
        wb_we = 1'b0;
        check("same_cycle_wb", out_rs1_val, byp_exp);
        tick();
        check("after_wb", out_rs1_val, 32'hAA);

        // RV32E: rd=x20 is illegal, and writes to x20 do not alias x4.
        insn = 32'h00000A13;
        tick();
        check("e_rd20_illegal", {31'b0, r16_illegal}, 32'd1);
        check("e_rd20_reg_we", {31'b0, r16_reg_we}, 32'd0);
        check("i_rd20_legal", {31'b0, out_illegal}, 32'd0);
        check("i_rd20_reg_we", {31'b0, out_reg_we}, 32'd1);
        in_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h77;
        tick();
        wb_we = 1'b0; in_valid = 1'b1; insn = 32'h00020013;
        tick();
        check("e_x4_not_aliased", r16_rs1_val, 32'd0);
        insn = 32'h000A0013;
        tick();
        check("i_x20_written", out_rs1_val, 32'h77);

        // Reset together with flush clears every field.
        rst = 1'b1; flush = 1'b1;
        tick();
        check("rstflush_valid", {31'b0, out_valid}, 32'd0);
        check("rstflush_rd", {27'b0, out_rd}, 32'd0);
        check("rstflush_rs1", out_rs1_val, 32'd0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
